// File: rtl/rms_pkg.sv
// Shared types and default sizing for the RMS sliding-window datapath.
package rms_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int WINDOW_DEF  = 64;
    localparam int PTRBITS_DEF = $clog2(WINDOW_DEF);
    localparam int ACCW_DEF    = 2 * WIDTH_DEF + PTRBITS_DEF;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STEADY = 2'd1,
        SUB    = 2'd2,
        DRAIN  = 2'd3
    } rms_state_t;

endpackage

// File: rtl/rms_window_ctrl_square.sv
// Combinational signed square; the result is non-negative and fits 2*WIDTH bits unsigned.
module rms_square
    import rms_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-1:0]   x,
    output logic        [2*WIDTH-1:0] sq
);

    logic signed [2*WIDTH-1:0] x_ext;
    logic signed [2*WIDTH-1:0] prod;

    // Largest magnitude is (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2), so the sign bit stays clear.
    assign x_ext = {{WIDTH{x[WIDTH-1]}}, x};
    assign prod  = x_ext * x_ext;
    assign sq    = prod;

endmodule

// File: rtl/rms_window_ctrl.sv
// Sliding-window sum-of-squares controller; sequences an external fifo as a WINDOW-deep delay line.
module rms_window_ctrl
    import rms_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int WINDOW  = WINDOW_DEF,
    parameter int PTRBITS = $clog2(WINDOW),
    parameter int ACCW    = 2 * WIDTH + PTRBITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic                    sample_ready,
    input  logic                    flush,
    output logic                    fifo_write,
    output logic                    fifo_read,
    output logic        [WIDTH-1:0] fifo_datain,
    input  logic signed [WIDTH-1:0] fifo_dataout,
    input  logic                    fifo_full,
    input  logic                    fifo_empty,
    output logic        [ACCW-1:0]  sumsq,
    output logic                    sumsq_valid,
    output logic                    window_full
);

    localparam logic [PTRBITS:0] CNT_LAST = (PTRBITS + 1)'(WINDOW - 1);

    rms_state_t              state;
    rms_state_t              state_nx;
    logic [PTRBITS:0]        count;
    logic                    flush_pend;
    logic signed [WIDTH-1:0] hold;
    logic signed [WIDTH-1:0] sq_new_in;
    logic [2*WIDTH-1:0]      sq_new;
    logic [2*WIDTH-1:0]      sq_old;
    logic                    accept;

    function automatic logic [ACCW-1:0] widen(input logic [2*WIDTH-1:0] v);
        return ACCW'(v);
    endfunction

    rms_square #(.WIDTH(WIDTH)) u_sq_new (
        .x  (sq_new_in),
        .sq (sq_new)
    );

    rms_square #(.WIDTH(WIDTH)) u_sq_old (
        .x  (fifo_dataout),
        .sq (sq_old)
    );

    assign accept = sample_valid && sample_ready;

    always_comb begin
        state_nx     = state;
        sample_ready = 1'b0;
        fifo_write   = 1'b0;
        fifo_read    = 1'b0;
        fifo_datain  = sample_in;
        sq_new_in    = sample_in;
        case (state)
            FILL: begin
                sample_ready = !flush && !flush_pend && !fifo_full;
                if (flush || flush_pend) begin
                    state_nx = DRAIN;
                end else if (sample_valid && sample_ready) begin
                    fifo_write = 1'b1;
                    if (count == CNT_LAST) state_nx = STEADY;
                end
            end
            STEADY: begin
                sample_ready = !flush && !flush_pend;
                if (flush || flush_pend) begin
                    state_nx = DRAIN;
                end else if (sample_valid && sample_ready) begin
                    // Window is full: evict the oldest now, its data arrives next cycle.
                    fifo_read = 1'b1;
                    state_nx  = SUB;
                end
            end
            SUB: begin
                fifo_write  = 1'b1;
                fifo_datain = hold;
                sq_new_in   = hold;
                state_nx    = (flush || flush_pend) ? DRAIN : STEADY;
            end
            DRAIN: begin
                fifo_read = !fifo_empty;
                if (fifo_empty) state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            sumsq       <= '0;
            sumsq_valid <= 1'b0;
            window_full <= 1'b0;
            count       <= '0;
            flush_pend  <= 1'b0;
            hold        <= '0;
        end else begin
            state       <= state_nx;
            sumsq_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        sumsq <= sumsq + widen(sq_new);
                        count <= count + 1'b1;
                        if (count == CNT_LAST) begin
                            window_full <= 1'b1;
                            sumsq_valid <= 1'b1;
                        end
                    end
                end
                STEADY: begin
                    if (accept) hold <= sample_in;
                end
                SUB: begin
                    sumsq       <= sumsq - widen(sq_old) + widen(sq_new);
                    sumsq_valid <= 1'b1;
                    flush_pend  <= flush_pend || flush;
                end
                DRAIN: begin
                    sumsq       <= '0;
                    count       <= '0;
                    window_full <= 1'b0;
                    if (fifo_empty) flush_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rms_window_ctrl.sv
// Bench for rms_window_ctrl with WINDOW=4: behavioural fifo plus sum-of-squares scoreboard.
module tb_rms_window_ctrl;

    localparam int W   = 16;
    localparam int WIN = 4;
    localparam int PB  = 2;
    localparam int AW  = 2 * W + PB;

    logic                clk = 1'b0;
    logic                rst;
    logic                sample_valid;
    logic signed [W-1:0] sample_in;
    logic                sample_ready;
    logic                flush;
    logic                fifo_write;
    logic                fifo_read;
    logic [W-1:0]        fifo_datain;
    logic [W-1:0]        fifo_dataout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW-1:0]       sumsq;
    logic                sumsq_valid;
    logic                window_full;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_cnt   = 0;
    int          pulse_cnt = 0;
    logic        mon_en = 1'b0;
    logic        rd_at_accept;
    logic [63:0] exp_q[$];
    int          win_q[$];

    always #5 clk = ~clk;

    rms_window_ctrl #(.WIDTH(W), .WINDOW(WIN), .PTRBITS(PB), .ACCW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .flush        (flush),
        .fifo_write   (fifo_write),
        .fifo_read    (fifo_read),
        .fifo_datain  (fifo_datain),
        .fifo_dataout (fifo_dataout),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .sumsq        (sumsq),
        .sumsq_valid  (sumsq_valid),
        .window_full  (window_full)
    );

    // Behavioural fifo: registered dataout, reads on empty and writes on full are ignored.
    logic [W-1:0] fmem [WIN];
    logic [PB:0]  fcnt;
    logic [PB-1:0] fwp, frp;
    logic [W-1:0] fdout;
    logic         do_rd, do_wr;

    assign fifo_full    = (fcnt == 3'(WIN));
    assign fifo_empty   = (fcnt == 3'd0);
    assign fifo_dataout = fdout;
    assign do_rd        = fifo_read && !fifo_empty;
    assign do_wr        = fifo_write && (!fifo_full || do_rd);

    always @(posedge clk) begin
        if (rst) begin
            fcnt  <= '0;
            fwp   <= '0;
            frp   <= '0;
            fdout <= '0;
        end else begin
            if (do_wr) begin
                fmem[fwp] <= fifo_datain;
                fwp       <= fwp + 1'b1;
            end
            if (do_rd) begin
                fdout <= fmem[frp];
                frp   <= frp + 1'b1;
            end
            if (do_wr && !do_rd) fcnt <= fcnt + 1'b1;
            else if (do_rd && !do_wr) fcnt <= fcnt - 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst && fifo_read) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("wr_rd_excl", 64'(fifo_write & fifo_read), 64'd0);
            if (sumsq_valid) begin
                pulse_cnt <= pulse_cnt + 1;
                if (exp_q.size() == 0) chk("sb_unexpected", 64'(sumsq_valid), 64'd0);
                else chk("sb_sumsq", 64'(sumsq), exp_q.pop_front());
            end
        end
    end

    task automatic send(input int s);
        int     n;
        longint sum;
        @(negedge clk);
        sample_in    = 16'(s);
        sample_valid = 1'b1;
        #1;
        n = 0;
        while (!sample_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_ready", 64'(sample_ready), 64'd1);
        rd_at_accept = fifo_read;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        win_q.push_back(s);
        if (win_q.size() > WIN) void'(win_q.pop_front());
        if (win_q.size() == WIN) begin
            sum = 0;
            foreach (win_q[i]) sum += longint'(win_q[i]) * longint'(win_q[i]);
            exp_q.push_back(64'(sum));
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!sample_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 64'(sample_ready), 64'd1);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_ready();
        win_q.delete();
        chk("flush_sumsq", 64'(sumsq), 64'd0);
        chk("flush_empty", 64'(fifo_empty), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        logic signed [W-1:0] r16;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        flush        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sumsq", 64'(sumsq), 64'd0);
        chk("rst_valid", 64'(sumsq_valid), 64'd0);
        chk("rst_wfull", 64'(window_full), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        rst    = 1'b0;
        mon_en = 1'b1;
        #1 chk("rst_ready", 64'(sample_ready), 64'd1);

        // Fill 1..4
        base = pulse_cnt;
        for (int i = 1; i <= 4; i++) send(i);
        @(negedge clk);
        chk("fill_sumsq", 64'(sumsq), 64'd30);
        chk("fill_valid", 64'(sumsq_valid), 64'd1);
        chk("fill_wfull", 64'(window_full), 64'd1);
        chk("fill_ffull", 64'(fifo_full), 64'd1);
        @(negedge clk);
        chk("fill_pulses", 64'(pulse_cnt - base), 64'd1);
        chk("fill_valid_drop", 64'(sumsq_valid), 64'd0);

        // First slide
        send(5);
        chk("slide_rd_accept", 64'(rd_at_accept), 64'd1);
        @(negedge clk);
        chk("slide_ready_low", 64'(sample_ready), 64'd0);
        chk("slide_write", 64'(fifo_write), 64'd1);
        chk("slide_sum_hold", 64'(sumsq), 64'd30);
        @(negedge clk);
        chk("slide_sumsq", 64'(sumsq), 64'd54);
        chk("slide_valid", 64'(sumsq_valid), 64'd1);
        chk("slide_ready_back", 64'(sample_ready), 64'd1);

        // Signed and extreme values
        do_flush();
        for (int i = 0; i < 4; i++) send(-3);
        @(negedge clk);
        chk("neg3_sumsq", 64'(sumsq), 64'd36);
        do_flush();
        for (int i = 0; i < 4; i++) send(-32768);
        @(negedge clk);
        chk("min_sumsq", 64'(sumsq), 64'h1_0000_0000);
        for (int i = 0; i < 6; i++) begin
            r16 = 16'($urandom);
            send(int'(r16));
        end

        // Flush during SUB
        send(123);
        flush = 1'b1;
        base  = rd_cnt;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b0;
        wait_ready();
        win_q.delete();
        chk("fsub_reads", 64'(rd_cnt - base), 64'd4);
        chk("fsub_empty", 64'(fifo_empty), 64'd1);
        chk("fsub_sumsq", 64'(sumsq), 64'd0);
        chk("fsub_wfull", 64'(window_full), 64'd0);

        // Flush and sample together in FILL
        send(7);
        send(-7);
        @(negedge clk);
        flush        = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'sd9;
        #1;
        chk("fvs_write", 64'(fifo_write), 64'd0);
        chk("fvs_ready", 64'(sample_ready), 64'd0);
        base = rd_cnt;
        @(negedge clk);
        flush        = 1'b0;
        sample_valid = 1'b0;
        chk("fvs_drain", 64'(sample_ready), 64'd0);
        wait_ready();
        win_q.delete();
        chk("fvs_reads", 64'(rd_cnt - base), 64'd2);
        chk("fvs_empty", 64'(fifo_empty), 64'd1);

        // Reset during SUB
        for (int i = 1; i <= 4; i++) send(i);
        send(5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        win_q.delete();
        chk("rsub_sumsq", 64'(sumsq), 64'd0);
        chk("rsub_valid", 64'(sumsq_valid), 64'd0);
        chk("rsub_wfull", 64'(window_full), 64'd0);
        chk("rsub_empty", 64'(fifo_empty), 64'd1);
        chk("rsub_ready", 64'(sample_ready), 64'd1);
        for (int i = 1; i <= 4; i++) send(i);
        @(negedge clk);
        chk("refill_sumsq", 64'(sumsq), 64'd30);

        repeat (3) @(negedge clk);
        chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
